inst_sram_responder: RTL

INST_SRAM_RESPONDER -- requirements
Module: inst_sram_responder

---
 rtl/inst_sram_responder_pkg.sv | 22 ++
 rtl/inst_sram_responder_req_fifo.sv | 83 ++++++++
 rtl/inst_sram_responder.sv | 73 +++++++
 3 files changed

// File: rtl/inst_sram_responder_pkg.sv
// Shared definitions for the instruction-SRAM-like responder: access size codes
// and the fields carried by each queued request.
package inst_sram_responder_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int CD_W   = 3;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  typedef struct packed {
    logic              wr;
    size_e             size;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
  } req_fields_t;

endpackage

// File: rtl/inst_sram_responder_req_fifo.sv
// In-order request queue: circular buffer whose entries each count down the
// remaining cycles before they may be answered.
module sram_req_fifo
  import inst_sram_responder_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int IDX_W   = 10,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  req_fields_t      push_fields,
  input  logic [IDX_W-1:0] push_index,
  input  logic             pop,
  output req_fields_t      head_fields,
  output logic [IDX_W-1:0] head_index,
  output logic             head_ready,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CD_W-1:0]  CD_LOAD   = CD_W'(LATENCY - 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W + 1)'(DEPTH);

  req_fields_t      fields_mem [DEPTH];
  logic [IDX_W-1:0] index_mem  [DEPTH];
  logic [CD_W-1:0]  cd_reg     [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [PTR_W:0]   count_reg;

  // Payload needs no reset: an entry is only ever read while its valid bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      fields_mem[tail_reg] <= push_fields;
      index_mem[tail_reg]  <= push_index;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + PTR_ONE;
      if (pop)  head_reg <= head_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // A push never lands on the slot being popped: push needs !full, so tail != head
  // whenever the head is valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= '0;
      for (int i = 0; i < DEPTH; i++) cd_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && tail_reg == PTR_W'(i)) begin
          valid_reg[i] <= 1'b1;
          cd_reg[i]    <= CD_LOAD;
        end else begin
          if (pop && head_reg == PTR_W'(i)) valid_reg[i] <= 1'b0;
          if (cd_reg[i] != '0) cd_reg[i] <= cd_reg[i] - CD_W'(1);
        end
      end
    end
  end

  assign head_fields = fields_mem[head_reg];
  assign head_index  = index_mem[head_reg];
  assign head_ready  = valid_reg[head_reg] && (cd_reg[head_reg] == '0);
  assign full        = (count_reg == CNT_DEPTH);

endmodule

// File: rtl/inst_sram_responder.sv
// SRAM-like slave model: accepts up to OUTSTANDING requests and answers each,
// in order, LATENCY cycles later from a word-wide backing array.
module inst_sram_responder
  import inst_sram_responder_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int OUTSTANDING = 4,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [DATA_W-1:0] rdata
);

  localparam int WORDS = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [WORDS];

  req_fields_t       push_fields, head_fields;
  logic [ADDR_W-1:0] head_index;
  logic              head_ready, full, accept;
  logic [DATA_W-1:0] old_word, new_word;
  logic              unused_bits;

  // Gating with reset keeps the window closed for the whole reset pulse.
  assign addr_ok     = !reset && !full;
  assign accept      = req && addr_ok;
  assign push_fields = '{wr: wr, size: size_e'(size), wstrb: wstrb, wdata: wdata};

  sram_req_fifo #(
    .DEPTH   (OUTSTANDING),
    .IDX_W   (ADDR_W),
    .LATENCY (LATENCY)
  ) u_req_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (accept),
    .push_fields (push_fields),
    .push_index  (addr[ADDR_W+1:2]),
    .pop         (head_ready),
    .head_fields (head_fields),
    .head_index  (head_index),
    .head_ready  (head_ready),
    .full        (full)
  );

  assign data_ok  = head_ready;
  assign old_word = mem[head_index];
  assign rdata    = (head_ready && !head_fields.wr) ? old_word : '0;

  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
      assign new_word[gi*8 +: 8] = head_fields.wstrb[gi] ? head_fields.wdata[gi*8 +: 8]
                                                         : old_word[gi*8 +: 8];
    end
  endgenerate

  // Writes retire at the end of their data_ok cycle, so a younger read sees them.
  always_ff @(posedge clk) begin
    if (head_ready && head_fields.wr) mem[head_index] <= new_word;
  end

  assign unused_bits = ^{addr[31:ADDR_W+2], addr[1:0], head_fields.size};

endmodule
